systolic_row_feeder: RTL
========================

// Module: systolic_row_feeder
// PURPOSE
//  Upstream stage of the PE array. Buffers one ROWS x K_DEPTH tile of MXFP8 E4M3 operands.
//  Tiles arrive through a valid/ready byte stream.
//  Each row r is replayed into the array's west edge (the PE a_in chain) with an r-cycle
//  diagonal skew. The block also issues the accumulator clear before each tile and
//  pulses tile_done once the array has drained.
// PARAMETERS
//  ROWS       4   array rows = number of skewed output lanes
//  K_DEPTH    4   elements per row (reduction length)
//  DATA_W     8   element width (E4M3 byte)
//  DRAIN_CYC  8   zero-fill cycles after the last element, covering PE pipeline + array traversal
// PORTS
//  clk        in   1              clock
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              load beat valid
//  in_ready   out  1              feeder can accept a beat
//  in_data    in   DATA_W         element; row-major order (r0k0, r0k1, ... r1k0, ...)
//  a_row      out  ROWS*DATA_W    lane r at bits [r*DATA_W +: DATA_W]; drives row r of the array
//  clear_out  out  1              accumulator clear to all PEs
//  busy       out  1              high in CLEAR, FEED and DRAIN
//  tile_done  out  1              one-cycle pulse at end of DRAIN
// BEHAVIOUR
//  Reset: a_row=0, clear_out=0, busy=0, tile_done=0, in_ready=0 on the reset cycle.
//   All counters are zeroed, all banks are marked empty and the FSM goes to LOAD.
//   The same applies mid-tile: any partial tile is discarded.
//  Transfer: a beat is accepted on a rising edge with in_valid & in_ready.
//   No beat is accepted while in_ready=0; the sender holds in_data stable.
//  FSM states and transitions:
//   LOAD  -> CLEAR when the bank holds all ROWS*K_DEPTH elements
//            (the cycle after the final beat, or immediately if a full bank is already waiting)
//   CLEAR -> FEED after 1 cycle; clear_out=1, a_row=0 throughout CLEAR
//   FEED  -> DRAIN after T = K_DEPTH+ROWS-1 cycles
//            feed step t = 0..T-1
//            lane r = buf[r][t-r] when 0 <= t-r < K_DEPTH, else 0
//   DRAIN -> LOAD after DRAIN_CYC cycles with a_row=0
//            tile_done=1 on the last DRAIN cycle; that bank is released
//  Outputs a_row, clear_out and tile_done are registered; step t appears on a_row in feed cycle t.
//  Load counter wraps from ROWS*K_DEPTH-1 to 0.
//   When the final beat coincides with the bank-release cycle (DBUF only), the release takes
//   effect first, so no stall results.
//  clear_out and tile_done are never high in the same cycle. busy=0 in LOAD.
// CONFIGURATION
//  SYSTOLIC_FEEDER_DBUF_EN
//   defined: two banks in ping-pong.
//    in_ready=1 whenever the write bank is not full, in any FSM state.
//    FEED/DRAIN read the other bank.
//    LOAD->CLEAR fires as soon as the read bank is full.
//    Back-to-back tiles incur exactly 1 LOAD cycle between DRAIN and CLEAR.
//   undefined: single bank. in_ready=1 only in LOAD while the bank is not full.
// STRUCTURE
//  Shared package tpu_pkg:
//   - FSM state encoding (LOAD/CLEAR/FEED/DRAIN)
//   - E4M3_ZERO = 8'h00
//   - clog2-based counter width helpers
//  Sub-module feeder_bank:
//   - ROWS x K_DEPTH register file with write pointer and full flag
//   - combinational per-lane skewed read port indexed by t
//   - instantiated once, or twice under DBUF
// TESTING
//  1 ROWS=2, K_DEPTH=3: load 01..06 back-to-back.
//    -> one CLEAR cycle, then a_row lanes (r0,r1) = (01,00), (02,04), (03,05), (00,06).
//    -> then 8 zero cycles; tile_done on the 8th.
//  2 Random in_valid gaps during load.
//    -> identical a_row sequence to test 1; no beat lost or duplicated.
//  3 Assert rst during FEED step 2.
//    -> next cycle all outputs 0 and in_ready=1.
//    -> a fresh tile 11..16 feeds (11,00), (12,14), ... with no stale data.
//  4 Without DBUF: hold in_valid high through FEED.
//    -> in_ready=0 from CLEAR until after tile_done; zero beats accepted.
//  5 With DBUF: stream 12 beats continuously.
//    -> second tile fully accepted during first FEED/DRAIN.
//    -> its CLEAR starts 1 cycle after the first tile_done.
//  6 Defaults (4x4): check busy spans exactly 1+7+8 = 16 cycles.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the PE-array front end: feeder FSM encoding,
// the E4M3 zero code and counter-width helpers.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_DRAIN = 2'd3
    } feed_state_t;

    localparam logic [7:0] E4M3_ZERO = 8'h00;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/feeder_bank.sv
// One ROWS x K_DEPTH operand tile: row-major write port with full flag,
// and a combinational read port that applies the diagonal skew for step t.
module feeder_bank
    import tpu_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int K_DEPTH = 4,
    parameter int DATA_W  = 8,
    parameter int TW      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_release,
    input  logic [TW-1:0]            i_t,
    output logic                     o_full,
    output logic [ROWS*DATA_W-1:0]   o_lanes
);

    localparam int N  = ROWS * K_DEPTH;
    localparam int PW = cnt_w(N);

    logic [PW-1:0]     r_wptr;
    logic              r_full;
    logic [DATA_W-1:0] r_mem [N];
    logic              w_last;

    assign w_last = (r_wptr == PW'(N - 1));
    assign o_full = r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_release)
                r_full <= 1'b0;
            if (i_we) begin
                r_wptr <= w_last ? '0 : r_wptr + 1'b1;
                if (w_last)
                    r_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[r_wptr] <= i_wdata;
    end

    // Lane r shows element k of its row when t == r + k.
    always_comb begin
        o_lanes = '0;
        for (int r = 0; r < ROWS; r++) begin
            o_lanes[r*DATA_W +: DATA_W] = DATA_W'(E4M3_ZERO);
            for (int k = 0; k < K_DEPTH; k++) begin
                if (int'(i_t) == r + k)
                    o_lanes[r*DATA_W +: DATA_W] = r_mem[r*K_DEPTH + k];
            end
        end
    end

endmodule

// File: rtl/systolic_row_feeder.sv
// West-edge operand feeder for the PE array: loads a tile, clears, feeds skewed rows, drains.
// Define SYSTOLIC_FEEDER_DBUF_EN for ping-pong banks that load during FEED/DRAIN.
module systolic_row_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int K_DEPTH   = 4,
    parameter int DATA_W    = 8,
    parameter int DRAIN_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic [ROWS*DATA_W-1:0] a_row,
    output logic                   clear_out,
    output logic                   busy,
    output logic                   tile_done
);

    localparam int T  = K_DEPTH + ROWS - 1;
    localparam int CW = cnt_w(max_i(T, DRAIN_CYC));

    feed_state_t             r_state;
    feed_state_t             w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_accept;
    logic                    w_release;
    logic                    w_rd_full;
    logic [ROWS*DATA_W-1:0]  w_rd_lanes;

    assign w_accept  = in_valid && in_ready;
    assign w_release = (r_state == ST_DRAIN) && (r_cnt == CW'(DRAIN_CYC - 1));
    assign busy      = !rst && (r_state != ST_LOAD);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    logic                   r_rsel;
    logic                   w_wsel;
    logic [1:0]             w_full;
    logic [ROWS*DATA_W-1:0] w_lanes [2];

    // Writes go to the read bank until it fills, then to its partner.
    assign w_wsel     = w_full[r_rsel] ? ~r_rsel : r_rsel;
    assign w_rd_full  = w_full[r_rsel];
    assign w_rd_lanes = w_lanes[r_rsel];
    assign in_ready   = !rst && !w_full[w_wsel];

    always_ff @(posedge clk) begin
        if (rst)
            r_rsel <= 1'b0;
        else if (w_release)
            r_rsel <= ~r_rsel;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        feeder_bank #(
            .ROWS(ROWS), .K_DEPTH(K_DEPTH), .DATA_W(DATA_W), .TW(CW)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .i_we     (w_accept && (w_wsel == 1'(b))),
            .i_wdata  (in_data),
            .i_release(w_release && (r_rsel == 1'(b))),
            .i_t      (w_cnt_nxt),
            .o_full   (w_full[b]),
            .o_lanes  (w_lanes[b])
        );
    end
`else
    assign in_ready = !rst && (r_state == ST_LOAD) && !w_rd_full;

    feeder_bank #(
        .ROWS(ROWS), .K_DEPTH(K_DEPTH), .DATA_W(DATA_W), .TW(CW)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_accept),
        .i_wdata  (in_data),
        .i_release(w_release),
        .i_t      (w_cnt_nxt),
        .o_full   (w_rd_full),
        .o_lanes  (w_rd_lanes)
    );
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_LOAD: begin
                if (w_rd_full) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_FEED;
                w_cnt_nxt   = '0;
            end
            ST_FEED: begin
                if (r_cnt == CW'(T - 1)) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_release) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so step t lands in feed cycle t.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_cnt     <= '0;
            a_row     <= '0;
            clear_out <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            a_row     <= (w_state_nxt == ST_FEED) ? w_rd_lanes : '0;
            clear_out <= (w_state_nxt == ST_CLEAR);
            tile_done <= (w_state_nxt == ST_DRAIN) &&
                         (w_cnt_nxt == CW'(DRAIN_CYC - 1));
        end
    end

endmodule
